// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg: shared state encoding and operation-mode constants
// for the chunked adder/subtractor and its chunk adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Values of the sub input
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Values of the is_signed input
    localparam logic UNSIGNED = 1'b0;
    localparam logic SIGNED   = 1'b1;

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// chunk_add: CHUNK-bit combinational adder slice. Besides the sum and the
// carry out it reports the carry into its top bit, which the parent needs
// for the two's-complement overflow rule.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum   = total[CHUNK-1:0];
    assign cout  = total[CHUNK];
    // The sum bit at the top is a ^ b ^ carry-in, so the carry into the top
    // bit falls out without a second adder (also holds for CHUNK == 1).
    assign c_msb = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder/subtractor that works CHUNK
// bits per clock, LSB chunk first, behind valid/ready handshakes.
// Optional feature macro: CHUNKED_ADDER_SAT_EN saturates the result when
// overflow is flagged; without it the result wraps modulo 2^WIDTH.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             carry
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aOp_q, aOp_d;
    logic [WIDTH-1:0] bOp_q, bOp_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             runCarry_q, runCarry_d;
    logic             sub_q, sub_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carryOut_q, carryOut_d;
    logic             overflow_q, overflow_d;

    logic [CHUNK-1:0] aView [NCHUNK];
    logic [CHUNK-1:0] bView [NCHUNK];
    logic [CHUNK-1:0] sumChunk;
    logic             chunkCout;
    logic             chunkCMsb;
    logic [WIDTH-1:0] resMerged;
    logic [WIDTH-1:0] finalResult;
    logic             ovfNext;

    for (genvar k = 0; k < NCHUNK; k++) begin : g_view
        assign aView[k] = aOp_q[k*CHUNK +: CHUNK];
        assign bView[k] = bOp_q[k*CHUNK +: CHUNK];
    end

    chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a     (aView[idx_q]),
        .b     (bView[idx_q]),
        .cin   (runCarry_q),
        .sum   (sumChunk),
        .cout  (chunkCout),
        .c_msb (chunkCMsb)
    );

    // Result register with the current chunk's sum dropped into its slot
    always_comb begin
        resMerged = res_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (IDX_W'(k) == idx_q) begin
                resMerged[k*CHUNK +: CHUNK] = sumChunk;
            end
        end
    end

    // Overflow as seen on the last chunk; only loaded into overflow_q then
    assign ovfNext = (signed_q == SIGNED)  ? (chunkCMsb ^ chunkCout) :
                     (sub_q == ADD)        ? chunkCout : !chunkCout;

`ifdef CHUNKED_ADDER_SAT_EN
    // Clamp to the nearest representable bound when the result overflowed
    always_comb begin
        finalResult = resMerged;
        if (ovfNext) begin
            if (signed_q == UNSIGNED) begin
                finalResult = (sub_q == SUB) ? '0 : '1;
            end else if (aOp_q[WIDTH-1]) begin
                finalResult = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                finalResult = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end
`else
    assign finalResult = resMerged;
`endif

    // Next-state and datapath update for IDLE -> RUN -> DONE
    always_comb begin
        state_d    = state_q;
        aOp_d      = aOp_q;
        bOp_d      = bOp_q;
        res_d      = res_q;
        idx_d      = idx_q;
        runCarry_d = runCarry_q;
        sub_d      = sub_q;
        signed_d   = signed_q;
        out_d      = out_q;
        carryOut_d = carryOut_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    aOp_d      = in1;
                    bOp_d      = in2 ^ {WIDTH{sub}};
                    sub_d      = sub;
                    signed_d   = is_signed;
                    runCarry_d = (sub == SUB);
                    idx_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                res_d      = resMerged;
                runCarry_d = chunkCout;
                if (idx_q == LAST_IDX) begin
                    out_d      = finalResult;
                    carryOut_d = chunkCout;
                    overflow_d = ovfNext;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            aOp_q      <= '0;
            bOp_q      <= '0;
            res_q      <= '0;
            idx_q      <= '0;
            runCarry_q <= 1'b0;
            sub_q      <= 1'b0;
            signed_q   <= 1'b0;
            out_q      <= '0;
            carryOut_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            aOp_q      <= aOp_d;
            bOp_q      <= bOp_d;
            res_q      <= res_d;
            idx_q      <= idx_d;
            runCarry_q <= runCarry_d;
            sub_q      <= sub_d;
            signed_q   <= signed_d;
            out_q      <= out_d;
            carryOut_q <= carryOut_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign carry     = carryOut_q;
    assign overflow  = overflow_q;

endmodule
